// File: rtl/soc_system_sysid_ext.sv
// System-ID slave with build identity words, a free-running uptime counter with an atomic
// 64-bit snapshot, a scratch register and a control register, behind a pipelined read port.
module soc_system_sysid_ext #(
  parameter logic [31:0] SYSID        = 32'hACD5_CD02,
  parameter logic [31:0] TIMESTAMP    = 32'h53A0_6C30,
  parameter logic [31:0] VERSION      = 32'h0001_0000,
  parameter int unsigned READ_LATENCY = 1,
  parameter int unsigned CNT_W        = 48,
  // Counter value loaded by reset; leave at zero outside of simulation.
  parameter logic [63:0] CNT_PRESET   = 64'd0
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [2:0]  address,
  input  logic        read,
  input  logic        write,
  input  logic [31:0] writedata,
  input  logic [3:0]  byteenable,
  output logic [31:0] readdata,
  output logic        readdatavalid
);

  localparam logic [31:0] Caps = {17'd0, CNT_W[6:0], 4'd0, READ_LATENCY[3:0]};

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [63:0]      cnt_ext;
  logic [31:0]      shadow_q, shadow_d;
  logic [31:0]      scratch_q, scratch_d;
  logic             freeze_q, freeze_d;
  logic             rd_acc, wr_ctrl, clr;
  logic [31:0]      rd_mux;

  logic [READ_LATENCY-1:0] vld_q;
  logic [31:0]             dat_q [READ_LATENCY];

  assign cnt_ext = 64'(cnt_q);

  always_comb begin
    rd_acc  = read & ~write;
    wr_ctrl = write & (address == 3'd7) & byteenable[0];
    clr     = wr_ctrl & writedata[0];

    rd_mux = '0;
    unique case (address)
      3'd0: rd_mux = SYSID;
      3'd1: rd_mux = TIMESTAMP;
      3'd2: rd_mux = VERSION;
      3'd3: rd_mux = Caps;
      3'd4: rd_mux = cnt_ext[31:0];
      3'd5: rd_mux = shadow_q;
      3'd6: rd_mux = scratch_q;
      3'd7: rd_mux = {30'd0, freeze_q, 1'b0};
      default: rd_mux = '0;
    endcase

    // The LO read latches the upper half so a later HI read is coherent with it.
    shadow_d = shadow_q;
    if (rd_acc && address == 3'd4) begin
      shadow_d = cnt_ext[63:32];
    end

    scratch_d = scratch_q;
    for (int i = 0; i < 4; i++) begin
      if (write && address == 3'd6 && byteenable[i]) begin
        scratch_d[8*i +: 8] = writedata[8*i +: 8];
      end
    end

    freeze_d = wr_ctrl ? writedata[1] : freeze_q;

    if (clr) begin
      cnt_d = '0;
    end else if (freeze_q) begin
      cnt_d = cnt_q;
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      cnt_q     <= CNT_PRESET[CNT_W-1:0];
      shadow_q  <= '0;
      scratch_q <= '0;
      freeze_q  <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      shadow_q  <= shadow_d;
      scratch_q <= scratch_d;
      freeze_q  <= freeze_d;
    end
  end

  // Data is zeroed on idle slots so readdata is 0 whenever readdatavalid is low.
  always_ff @(posedge clock) begin
    if (reset) begin
      vld_q <= '0;
      for (int i = 0; i < int'(READ_LATENCY); i++) begin
        dat_q[i] <= '0;
      end
    end else begin
      vld_q[0] <= rd_acc;
      dat_q[0] <= rd_acc ? rd_mux : 32'd0;
      for (int i = 1; i < int'(READ_LATENCY); i++) begin
        vld_q[i] <= vld_q[i-1];
        dat_q[i] <= dat_q[i-1];
      end
    end
  end

  assign readdatavalid = vld_q[READ_LATENCY-1];
  assign readdata      = vld_q[READ_LATENCY-1] ? dat_q[READ_LATENCY-1] : 32'd0;

endmodule

// File: tb/tb_soc_system_sysid_ext.sv
// Drives three differently parameterised instances with shared stimulus and compares every
// response cycle against a queue-based transaction model, plus directed corner-case sequences.
module tb_soc_system_sysid_ext;

  localparam int NDUT = 3;

  logic        clock = 1'b0;
  logic        reset, read, write;
  logic [2:0]  address;
  logic [31:0] writedata;
  logic [3:0]  byteenable;
  logic [31:0] rd0, rd1, rd2;
  logic        rv0, rv1, rv2;

  always #5 clock = ~clock;

  soc_system_sysid_ext #(.READ_LATENCY(1), .CNT_W(48)) dut_a (
    .clock(clock), .reset(reset), .address(address), .read(read), .write(write),
    .writedata(writedata), .byteenable(byteenable), .readdata(rd0), .readdatavalid(rv0));

  soc_system_sysid_ext #(.READ_LATENCY(3), .CNT_W(40), .CNT_PRESET(64'h0_FFFF_FF00)) dut_b (
    .clock(clock), .reset(reset), .address(address), .read(read), .write(write),
    .writedata(writedata), .byteenable(byteenable), .readdata(rd1), .readdatavalid(rv1));

  soc_system_sysid_ext #(.READ_LATENCY(4), .CNT_W(33), .CNT_PRESET(64'h1_FFFF_FF00)) dut_c (
    .clock(clock), .reset(reset), .address(address), .read(read), .write(write),
    .writedata(writedata), .byteenable(byteenable), .readdata(rd2), .readdatavalid(rv2));

  typedef struct {
    int          dut;
    int          due;
    logic [31:0] data;
  } resp_t;

  typedef struct {
    logic [2:0]  addr;
    logic [31:0] exp0;
    logic [31:0] exp1;
    logic [31:0] exp2;
  } vec_t;

  int checks = 0;
  int passed = 0;
  int edge_n = 0;

  longint unsigned m_cnt [NDUT];
  logic [31:0]     m_shadow [NDUT];
  logic [31:0]     m_scratch;
  logic            m_freeze;
  resp_t           mq[$];

  logic            obs_v [NDUT];
  logic [31:0]     obs_d [NDUT];
  logic [31:0]     cap_d [NDUT];
  int              cap_n [NDUT];
  int              cap_k [NDUT];

  function automatic int lat(int d);
    return (d == 0) ? 1 : ((d == 1) ? 3 : 4);
  endfunction

  function automatic int cw(int d);
    return (d == 0) ? 48 : ((d == 1) ? 40 : 33);
  endfunction

  function automatic longint unsigned pre(int d);
    return (d == 0) ? 64'd0 : ((d == 1) ? 64'h0_FFFF_FF00 : 64'h1_FFFF_FF00);
  endfunction

  function automatic logic [31:0] mreg(int d, logic [2:0] a);
    case (a)
      3'd0: return 32'hACD5_CD02;
      3'd1: return 32'h53A0_6C30;
      3'd2: return 32'h0001_0000;
      3'd3: return 32'(cw(d) * 256 + lat(d));
      3'd4: return 32'(m_cnt[d]);
      3'd5: return m_shadow[d];
      3'd6: return m_scratch;
      default: return m_freeze ? 32'd2 : 32'd0;
    endcase
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  task automatic step(input logic r, input logic w, input logic [2:0] a, input logic [31:0] wd,
                      input logic [3:0] be, input logic rs);
    logic        clr;
    logic        fz_old;
    logic        ev;
    logic [31:0] ed;
    int          idx;
    reset = rs; read = r; write = w; address = a; writedata = wd; byteenable = be;
    clr = 1'b0;
    fz_old = m_freeze;
    if (rs) begin
      for (int d = 0; d < NDUT; d++) begin
        m_cnt[d] = pre(d);
        m_shadow[d] = '0;
      end
      m_scratch = '0;
      m_freeze = 1'b0;
      mq.delete();
    end else begin
      if (r && !w) begin
        for (int d = 0; d < NDUT; d++) begin
          mq.push_back('{dut: d, due: edge_n + lat(d) - 1, data: mreg(d, a)});
          if (a == 3'd4) m_shadow[d] = 32'(m_cnt[d] >> 32);
        end
      end
      if (w && a == 3'd6) begin
        for (int i = 0; i < 4; i++) if (be[i]) m_scratch[8*i +: 8] = wd[8*i +: 8];
      end
      if (w && a == 3'd7 && be[0]) begin
        m_freeze = wd[1];
        clr = wd[0];
      end
      for (int d = 0; d < NDUT; d++) begin
        if (clr) m_cnt[d] = 0;
        else if (!fz_old) m_cnt[d] = (m_cnt[d] + 1) & ((64'd1 << cw(d)) - 1);
      end
    end
    @(posedge clock);
    #1;
    obs_v[0] = rv0; obs_d[0] = rd0;
    obs_v[1] = rv1; obs_d[1] = rd1;
    obs_v[2] = rv2; obs_d[2] = rd2;
    for (int d = 0; d < NDUT; d++) begin
      ev = 1'b0;
      ed = '0;
      idx = -1;
      for (int i = 0; i < mq.size(); i++) begin
        if (idx < 0 && mq[i].dut == d) idx = i;
      end
      if (idx >= 0 && mq[idx].due == edge_n) begin
        ev = 1'b1;
        ed = mq[idx].data;
        mq.delete(idx);
      end
      check($sformatf("resp cyc%0d dut%0d", edge_n, d), {31'd0, obs_v[d], obs_d[d]},
            {31'd0, ev, ed});
    end
    edge_n++;
  endtask

  task automatic idle();
    step(1'b0, 1'b0, 3'd0, 32'd0, 4'd0, 1'b0);
  endtask

  task automatic wr(input logic [2:0] a, input logic [31:0] wd, input logic [3:0] be);
    step(1'b0, 1'b1, a, wd, be, 1'b0);
  endtask

  // Issue one read (or read+write when w=1) and watch all instances for six cycles.
  task automatic rd_capture(input logic [2:0] a, input logic w, input logic [31:0] wd);
    for (int d = 0; d < NDUT; d++) begin
      cap_d[d] = '0; cap_n[d] = 0; cap_k[d] = -1;
    end
    for (int k = 0; k < 6; k++) begin
      if (k == 0) step(1'b1, w, a, wd, 4'hF, 1'b0);
      else idle();
      for (int d = 0; d < NDUT; d++) begin
        if (obs_v[d]) begin
          cap_d[d] = obs_d[d]; cap_n[d]++; cap_k[d] = k;
        end
      end
    end
  endtask

  vec_t        tbl [4];
  logic        hist_v [10];
  logic [31:0] hist_d [10];
  logic [31:0] lo_b, hi_b, hi_c;
  int          guard;

  initial begin
    tbl[0] = '{3'd0, 32'hACD5_CD02, 32'hACD5_CD02, 32'hACD5_CD02};
    tbl[1] = '{3'd1, 32'h53A0_6C30, 32'h53A0_6C30, 32'h53A0_6C30};
    tbl[2] = '{3'd2, 32'h0001_0000, 32'h0001_0000, 32'h0001_0000};
    tbl[3] = '{3'd3, 32'h0000_3001, 32'h0000_2803, 32'h0000_2104};

    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 3'd0, 32'd0, 4'd0, 1'b1);
    check("rv after reset", {63'd0, rv0}, 64'd0);

    for (int i = 0; i < 4; i++) begin
      rd_capture(tbl[i].addr, 1'b0, 32'd0);
      check($sformatf("tbl%0d a data", i), 64'(cap_d[0]), 64'(tbl[i].exp0));
      check($sformatf("tbl%0d b data", i), 64'(cap_d[1]), 64'(tbl[i].exp1));
      check($sformatf("tbl%0d c data", i), 64'(cap_d[2]), 64'(tbl[i].exp2));
      check($sformatf("tbl%0d a pulses", i), 64'(cap_n[0]), 64'd1);
      check($sformatf("tbl%0d a latency", i), 64'(cap_k[0]), 64'd0);
    end

    // Snapshot across the 32-bit carry on the 40-bit instance; 33-bit instance wraps here.
    guard = 0;
    while (m_cnt[1] != 64'hFFFF_FFFF && guard < 1000) begin
      idle();
      guard++;
    end
    check("reach carry", 64'(m_cnt[1]), 64'hFFFF_FFFF);
    rd_capture(3'd4, 1'b0, 32'd0);
    lo_b = cap_d[1];
    rd_capture(3'd5, 1'b0, 32'd0);
    hi_b = cap_d[1];
    check("snap1 lo", 64'(lo_b), 64'hFFFF_FFFF);
    check("snap1 hi", 64'(hi_b), 64'd0);
    rd_capture(3'd4, 1'b0, 32'd0);
    rd_capture(3'd5, 1'b0, 32'd0);
    hi_b = cap_d[1];
    hi_c = cap_d[2];
    check("snap2 hi", 64'(hi_b), 64'd1);
    check("wrap hi", 64'(hi_c), 64'd0);

    // Back-to-back reads on the latency-3 instance.
    step(1'b1, 1'b0, 3'd0, 32'd0, 4'd0, 1'b0);
    hist_v[0] = obs_v[1]; hist_d[0] = obs_d[1];
    step(1'b1, 1'b0, 3'd1, 32'd0, 4'd0, 1'b0);
    hist_v[1] = obs_v[1]; hist_d[1] = obs_d[1];
    step(1'b1, 1'b0, 3'd6, 32'd0, 4'd0, 1'b0);
    hist_v[2] = obs_v[1]; hist_d[2] = obs_d[1];
    step(1'b1, 1'b0, 3'd3, 32'd0, 4'd0, 1'b0);
    hist_v[3] = obs_v[1]; hist_d[3] = obs_d[1];
    for (int k = 4; k < 10; k++) begin
      idle();
      hist_v[k] = obs_v[1]; hist_d[k] = obs_d[1];
    end
    check("b2b gap0", {63'd0, hist_v[1]}, 64'd0);
    check("b2b v2", {63'd0, hist_v[2]}, 64'd1);
    check("b2b d2", 64'(hist_d[2]), 64'hACD5_CD02);
    check("b2b d3", 64'(hist_d[3]), 64'h53A0_6C30);
    check("b2b d4", {31'd0, hist_v[4], hist_d[4]}, {31'd0, 1'b1, 32'd0});
    check("b2b d5", {31'd0, hist_v[5], hist_d[5]}, {31'd0, 1'b1, 32'h0000_2803});
    check("b2b end", {63'd0, hist_v[6]}, 64'd0);

    wr(3'd6, 32'hDEAD_BEEF, 4'hF);
    wr(3'd6, 32'h1122_3344, 4'h5);
    rd_capture(3'd6, 1'b0, 32'd0);
    check("scratch bytes", 64'(cap_d[2]), 64'hDE22_BE44);
    wr(3'd0, 32'h1234_5678, 4'hF);
    rd_capture(3'd0, 1'b0, 32'd0);
    check("id ro", 64'(cap_d[0]), 64'hACD5_CD02);

    rd_capture(3'd6, 1'b1, 32'hCAFE_F00D);
    check("rw no resp", 64'(cap_n[0] + cap_n[1] + cap_n[2]), 64'd0);
    rd_capture(3'd6, 1'b0, 32'd0);
    check("rw write applied", 64'(cap_d[1]), 64'hCAFE_F00D);

    wr(3'd7, 32'd3, 4'h1);
    idle(); idle(); idle();
    rd_capture(3'd4, 1'b0, 32'd0);
    check("clr+freeze lo", 64'(cap_d[0]), 64'd0);
    rd_capture(3'd7, 1'b0, 32'd0);
    check("ctrl read", 64'(cap_d[0]), 64'd2);
    wr(3'd7, 32'd0, 4'h1);
    wr(3'd7, 32'd3, 4'h2);
    rd_capture(3'd7, 1'b0, 32'd0);
    check("ctrl be0 gate", 64'(cap_d[0]), 64'd0);

    for (int i = 0; i < 400; i++) begin
      step(1'($urandom_range(1)), ($urandom_range(3) == 0), 3'($urandom_range(7)),
           $urandom, 4'($urandom_range(15)), 1'b0);
    end
    for (int i = 0; i < 5; i++) idle();

    // Reset with reads in flight on every instance, including one in the reset cycle.
    step(1'b1, 1'b0, 3'd0, 32'd0, 4'd0, 1'b0);
    step(1'b1, 1'b0, 3'd1, 32'd0, 4'd0, 1'b0);
    step(1'b1, 1'b0, 3'd2, 32'd0, 4'd0, 1'b1);
    step(1'b0, 1'b0, 3'd0, 32'd0, 4'd0, 1'b1);
    guard = 0;
    for (int k = 0; k < 6; k++) begin
      idle();
      if (obs_v[0] || obs_v[1] || obs_v[2]) guard++;
    end
    check("flush no resp", 64'(guard), 64'd0);
    rd_capture(3'd6, 1'b0, 32'd0);
    check("scratch after reset", 64'(cap_d[2]), 64'd0);
    check("scratch resp seen", 64'(cap_n[2]), 64'd1);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
